// File: rtl/wide_arith_sequencer.sv
// Multi-word add/subtract sequencer driving a shared 16-bit ALU, LSW first with ADC carry chaining.
// Optional signed-overflow output enabled by defining WIDE_ARITH_OVF_EN.
module wide_arith_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic                  iOpSub,
    input  logic [16*WORDS-1:0]   iOperandA,
    input  logic [16*WORDS-1:0]   iOperandB,
    output logic [15:0]           oAluPortA,
    output logic [15:0]           oAluPortB,
    output logic [1:0]            oAluOpcode,
    input  logic [15:0]           iAluAccumulator,
    input  logic                  iAluCarry,
    output logic [16*WORDS-1:0]   oResult,
    output logic                  oCarryOut,
    output logic                  oZero,
    output logic                  oBusy,
    output logic                  oDone
`ifdef WIDE_ARITH_OVF_EN
    ,
    output logic                  oOverflow
`endif
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned WIDTH  = WORD_W * WORDS;
    localparam int unsigned IDX_W  = $clog2(WORDS);

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEED,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    // Select 16-bit word i of a wide vector.
    function automatic logic [WORD_W-1:0] word_of(input logic [WIDTH-1:0] v,
                                                  input logic [IDX_W-1:0] i);
        word_of = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (i == IDX_W'(k)) begin
                word_of = v[k*WORD_W +: WORD_W];
            end
        end
    endfunction

    assign oZero = (oResult == '0);

    // Sequencer: ALU port/opcode registers are loaded one cycle ahead of the state that uses them.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state      <= S_IDLE;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            oAluPortA  <= '0;
            oAluPortB  <= '0;
            oAluOpcode <= OP_IDLE;
            oResult    <= '0;
            oCarryOut  <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
`ifdef WIDE_ARITH_OVF_EN
            oOverflow  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        a_q   <= iOperandA;
                        b_q   <= iOpSub ? ~iOperandB : iOperandB;
                        idx   <= '0;
                        oBusy <= 1'b1;
                        if (iOpSub) begin
                            // Seed the ALU carry flag with the +1 of two's complement.
                            state      <= S_SEED;
                            oAluPortA  <= 16'hFFFF;
                            oAluPortB  <= 16'h0001;
                            oAluOpcode <= OP_ADD;
                        end else begin
                            state      <= S_ISSUE;
                            oAluPortA  <= iOperandA[WORD_W-1:0];
                            oAluPortB  <= iOperandB[WORD_W-1:0];
                            oAluOpcode <= OP_ADD;
                        end
                    end
                end
                S_SEED: begin
                    state      <= S_ISSUE;
                    oAluPortA  <= word_of(a_q, '0);
                    oAluPortB  <= word_of(b_q, '0);
                    oAluOpcode <= OP_ADC;
                end
                S_ISSUE: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (idx == IDX_W'(k)) begin
                            oResult[k*WORD_W +: WORD_W] <= iAluAccumulator;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state      <= S_DONE;
                        oDone      <= 1'b1;
                        oAluPortA  <= '0;
                        oAluPortB  <= '0;
                        oAluOpcode <= OP_IDLE;
                    end else begin
                        idx        <= idx + IDX_W'(1);
                        oAluPortA  <= word_of(a_q, idx + IDX_W'(1));
                        oAluPortB  <= word_of(b_q, idx + IDX_W'(1));
                        oAluOpcode <= OP_ADC;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    oDone     <= 1'b0;
                    oBusy     <= 1'b0;
                    oCarryOut <= iAluCarry;
`ifdef WIDE_ARITH_OVF_EN
                    // Same-sign operands producing an opposite-sign result.
                    oOverflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (oResult[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
